// File: rtl/audio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// audio_cmd_sequencer
//
// Shares the register bus of the SID-style audio block between the CPU and a
// hardware command queue.
//
// Operation:
//   - Commands (addr, data, post-write delay) are queued in a small FIFO.
//   - At each bus slot boundary (cpu_en_i) the block decides what to drive for
//     the following slot:
//       1. a pending CPU write;
//       2. otherwise, the FIFO head, if the sequencer is free;
//       3. otherwise, idle (rw=1, addr/data held).
//   - After a sequencer write, the block leaves cmd_delay idle slots before the
//     next sequencer write. Slots taken by the CPU count towards that wait.
//
// Optional feature (macro AUDIO_SEQ_LOOP_EN):
//   - Adds the input loop_i.
//   - While loop_i=1, every popped entry is re-appended to the tail, so the
//     queue replays forever.
//   - While loop_i=1, cmd_ready_o is held low.
//   - Without the macro, the loop_i port does not exist.
//
// Ports:
//   clk8_i        8 MHz clock (same as the audio block)
//   reset_i       asynchronous, active-high reset
//   cpu_en_i      one-cycle slot-boundary strobe
//   cpu_sel_i     CPU is addressing the audio register window
//   cpu_rw_ni     CPU read/write, low = write
//   cpu_addr_i    CPU register address
//   cpu_data_i    CPU write data
//   cmd_valid_i   command push request
//   cmd_ready_o   FIFO not full (and not looping)
//   cmd_addr_i    command register address
//   cmd_data_i    command write data
//   cmd_delay_i   idle slots to leave after this command's write
//   flush_i       empty the FIFO and abort any wait
//   loop_i        replay queue (only with AUDIO_SEQ_LOOP_EN)
//   audio_rw_no   to audio rw_ni
//   audio_addr_o  to audio addr_i
//   audio_data_o  to audio data_i
//   busy_o        sequencer not idle, or FIFO non-empty
//   fifo_count_o  current FIFO occupancy
// -----------------------------------------------------------------------------
module audio_cmd_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DELAY_W    = 16
) (
  input  logic                        clk8_i,
  input  logic                        reset_i,
  input  logic                        cpu_en_i,
  input  logic                        cpu_sel_i,
  input  logic                        cpu_rw_ni,
  input  logic [4:0]                  cpu_addr_i,
  input  logic [7:0]                  cpu_data_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [4:0]                  cmd_addr_i,
  input  logic [7:0]                  cmd_data_i,
  input  logic [DELAY_W-1:0]          cmd_delay_i,
  input  logic                        flush_i,
`ifdef AUDIO_SEQ_LOOP_EN
  input  logic                        loop_i,
`endif
  output logic                        audio_rw_no,
  output logic [4:0]                  audio_addr_o,
  output logic [7:0]                  audio_data_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state registers
  // ---------------------------------------------------------------------------
  logic [4:0]         r_mem_addr  [FIFO_DEPTH];
  logic [7:0]         r_mem_data  [FIFO_DEPTH];
  logic [DELAY_W-1:0] r_mem_delay [FIFO_DEPTH];

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DELAY_W-1:0] r_delay;
  logic [DELAY_W-1:0] w_delay_nxt;

  logic               r_cpu_pend;
  logic [4:0]         r_cpu_addr;
  logic [7:0]         r_cpu_data;

  logic               r_rw_n;
  logic [4:0]         r_addr;
  logic [7:0]         r_data;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic               w_loop;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_cpu_capture;
  logic               w_cpu_issue;
  logic               w_seq_free;
  logic               w_pop;
  logic               w_append;
  logic [4:0]         w_head_addr;
  logic [7:0]         w_head_data;
  logic [DELAY_W-1:0] w_head_delay;

`ifdef AUDIO_SEQ_LOOP_EN
  assign w_loop = loop_i;
`else
  assign w_loop = 1'b0;
`endif

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Readiness depends on the current occupancy only. A pop in the same
  // cycle does not make room for a push.
  assign cmd_ready_o = !w_full && !w_loop;

  // A flush in the same cycle drops the push.
  assign w_push = cmd_valid_i && cmd_ready_o && !flush_i;

  assign w_cpu_capture = cpu_en_i && cpu_sel_i && !cpu_rw_ni;
  assign w_cpu_issue   = cpu_en_i && r_cpu_pend;

  // The sequencer may issue at this boundary in two cases:
  //   - it is IDLE;
  //   - it has just issued a zero-delay command (back-to-back slots).
  // A wait that ends at this boundary returns to IDLE, so the next issue
  // happens one boundary later.
  assign w_seq_free = (r_state == S_IDLE) ||
                      ((r_state == S_ISSUE) && (r_delay == '0));

  assign w_pop = cpu_en_i && !r_cpu_pend && w_seq_free && !w_empty && !flush_i;

  // In loop mode the popped entry goes straight back to the tail.
  assign w_append = w_pop && w_loop;

  assign w_head_addr  = r_mem_addr[r_rd_ptr];
  assign w_head_data  = r_mem_data[r_rd_ptr];
  assign w_head_delay = r_mem_delay[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // FIFO storage (data path, not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk8_i) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= cmd_addr_i;
      r_mem_data[r_wr_ptr]  <= cmd_data_i;
      r_mem_delay[r_wr_ptr] <= cmd_delay_i;
    end else if (w_append) begin
      r_mem_addr[r_wr_ptr]  <= w_head_addr;
      r_mem_data[r_wr_ptr]  <= w_head_data;
      r_mem_delay[r_wr_ptr] <= w_head_delay;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  // The count is kept separately from the pointers so that full and empty are
  // never ambiguous. Both pointers wrap naturally, because the depth is a
  // power of two.
  always_ff @(posedge clk8_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push || w_append) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // A looping pop re-appends its entry, so the occupancy is unchanged.
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_loop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk8_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_delay <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next-state logic
  // ---------------------------------------------------------------------------
  // The counter holds the idle slots still owed. Each boundary after the
  // issuing boundary consumes one slot, including slots the CPU steals.
  // Within that boundary:
  //   - a counter of 1 returns to IDLE (that slot is the last idle one);
  //   - a counter of 0 from ISSUE returns to IDLE and lets the pop logic
  //     issue straight away.
  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_delay_nxt = '0;
    end else if (cpu_en_i) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_ISSUE, S_WAIT: begin
          if (r_delay > DELAY_W'(1)) begin
            w_delay_nxt = r_delay - DELAY_W'(1);
            w_state_nxt = S_WAIT;
          end else begin
            w_delay_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_delay_nxt = '0;
        end
      endcase
      if (w_pop) begin
        w_state_nxt = S_ISSUE;
        w_delay_nxt = w_head_delay;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU pending write: control flag
  // ---------------------------------------------------------------------------
  // A capture at a boundary always sets the flag. If a write was pending at
  // that boundary, it is driven now and the new capture replaces it.
  always_ff @(posedge clk8_i or posedge reset_i) begin
    if (reset_i) begin
      r_cpu_pend <= 1'b0;
    end else if (w_cpu_capture) begin
      r_cpu_pend <= 1'b1;
    end else if (w_cpu_issue) begin
      r_cpu_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU pending write: address and data (data path, not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk8_i) begin
    if (w_cpu_capture) begin
      r_cpu_addr <= cpu_addr_i;
      r_cpu_data <= cpu_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Audio bus slot register
  // ---------------------------------------------------------------------------
  // Updated only at a boundary, so the value is stable for the whole slot.
  // An idle slot releases rw and leaves addr/data as they were.
  always_ff @(posedge clk8_i or posedge reset_i) begin
    if (reset_i) begin
      r_rw_n <= 1'b1;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_cpu_issue) begin
      r_rw_n <= 1'b0;
      r_addr <= r_cpu_addr;
      r_data <= r_cpu_data;
    end else if (w_pop) begin
      r_rw_n <= 1'b0;
      r_addr <= w_head_addr;
      r_data <= w_head_data;
    end else if (cpu_en_i) begin
      r_rw_n <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign audio_rw_no  = r_rw_n;
  assign audio_addr_o = r_addr;
  assign audio_data_o = r_data;
  assign busy_o       = (r_state != S_IDLE) || !w_empty;
  assign fifo_count_o = r_count;

endmodule

// File: tb/tb_audio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_cmd_sequencer
//
// Self-checking bench for audio_cmd_sequencer.
//
// Stimulus tasks queue the expected content of each bus slot on a scoreboard.
// At every slot boundary the bench pops one entry and compares it with the
// audio outputs, both at the start and at the end of the slot.
//
// The loop-mode sequence is built only when AUDIO_SEQ_LOOP_EN is defined.
// -----------------------------------------------------------------------------
module tb_audio_cmd_sequencer;

  localparam int FIFO_DEPTH = 8;
  localparam int DELAY_W    = 16;

  logic               clk8_i = 1'b0;
  logic               reset_i;
  logic               cpu_en_i;
  logic               cpu_sel_i;
  logic               cpu_rw_ni;
  logic [4:0]         cpu_addr_i;
  logic [7:0]         cpu_data_i;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [4:0]         cmd_addr_i;
  logic [7:0]         cmd_data_i;
  logic [DELAY_W-1:0] cmd_delay_i;
  logic               flush_i;
  logic               audio_rw_no;
  logic [4:0]         audio_addr_o;
  logic [7:0]         audio_data_o;
  logic               busy_o;
  logic [3:0]         fifo_count_o;
`ifdef AUDIO_SEQ_LOOP_EN
  logic               loop_i;
`endif

  always #5 clk8_i = ~clk8_i;

  audio_cmd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DELAY_W    (DELAY_W)
  ) dut (
    .clk8_i       (clk8_i),
    .reset_i      (reset_i),
    .cpu_en_i     (cpu_en_i),
    .cpu_sel_i    (cpu_sel_i),
    .cpu_rw_ni    (cpu_rw_ni),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .cmd_delay_i  (cmd_delay_i),
    .flush_i      (flush_i),
`ifdef AUDIO_SEQ_LOOP_EN
    .loop_i       (loop_i),
`endif
    .audio_rw_no  (audio_rw_no),
    .audio_addr_o (audio_addr_o),
    .audio_data_o (audio_data_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  // Expected content of one bus slot.
  typedef struct {
    logic       rw;
    logic [4:0] addr;
    logic [7:0] data;
  } slot_t;

  // One table vector: the command to push, and the idle slots expected after
  // its write.
  typedef struct {
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [15:0] delay;
    int          exp_idle;
  } vec_t;

  slot_t      sb_q[$];
  logic [4:0] m_addr;
  logic [7:0] m_data;
  int         n_total = 0;
  int         n_bad   = 0;
  vec_t       vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk8_i);
    #1;
  endtask

  // Expected slot helpers: an idle slot keeps the last written addr/data.
  task automatic exp_write(input logic [4:0] a, input logic [7:0] d);
    slot_t e;
    e.rw   = 1'b0;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
    m_addr = a;
    m_data = d;
  endtask

  task automatic exp_idle();
    slot_t e;
    e.rw   = 1'b1;
    e.addr = m_addr;
    e.data = m_data;
    sb_q.push_back(e);
  endtask

  // One bus slot: a boundary edge followed by three ordinary cycles.
  // Any CPU/command strobes set up by the caller are applied at the boundary
  // edge and cleared right after it.
  task automatic bnd();
    slot_t e;
    bit    have;
    cpu_en_i = 1'b1;
    tick();
    cpu_en_i    = 1'b0;
    cpu_sel_i   = 1'b0;
    cpu_rw_ni   = 1'b1;
    cmd_valid_i = 1'b0;
    have = (sb_q.size() != 0);
    if (have) begin
      e = sb_q.pop_front();
      chk("slot_rw",   32'(audio_rw_no),  32'(e.rw));
      chk("slot_addr", 32'(audio_addr_o), 32'(e.addr));
      chk("slot_data", 32'(audio_data_o), 32'(e.data));
    end
    repeat (3) tick();
    if (have) begin
      chk("held_rw",   32'(audio_rw_no),  32'(e.rw));
      chk("held_addr", 32'(audio_addr_o), 32'(e.addr));
      chk("held_data", 32'(audio_data_o), 32'(e.data));
    end
  endtask

  // Command push on an ordinary (non-boundary) cycle.
  task automatic push_cmd(input logic [4:0] a, input logic [7:0] d,
                          input logic [15:0] dl);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    cmd_delay_i = dl;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    sb_q.delete();
    m_addr = '0;
    m_data = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int guard;

    reset_i     = 1'b1;
    cpu_en_i    = 1'b0;
    cpu_sel_i   = 1'b0;
    cpu_rw_ni   = 1'b1;
    cpu_addr_i  = '0;
    cpu_data_i  = '0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    cmd_delay_i = '0;
    flush_i     = 1'b0;
`ifdef AUDIO_SEQ_LOOP_EN
    loop_i      = 1'b0;
`endif

    vecs[0] = '{5'd24, 8'h1F, 16'd0, 0};
    vecs[1] = '{5'd0,  8'h34, 16'd0, 0};
    vecs[2] = '{5'd1,  8'h12, 16'd3, 3};
    vecs[3] = '{5'd7,  8'hA5, 16'd1, 1};
    vecs[4] = '{5'd31, 8'hFF, 16'd0, 0};
    vecs[5] = '{5'd2,  8'h00, 16'd2, 2};

    // ---- Reset state ----
    do_reset();
    chk("rst_rw",    32'(audio_rw_no),  32'd1);
    chk("rst_addr",  32'(audio_addr_o), 32'd0);
    chk("rst_data",  32'(audio_data_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o),  32'd1);
    chk("rst_busy",  32'(busy_o),       32'd0);

    // ---- Table-driven sequence ----
    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i].addr, vecs[i].data, vecs[i].delay);
      chk("tbl_count", 32'(fifo_count_o), 32'(i + 1));
      exp_write(vecs[i].addr, vecs[i].data);
      for (int k = 0; k < vecs[i].exp_idle; k++) begin
        exp_idle();
      end
    end
    chk("tbl_busy_q", 32'(busy_o), 32'd1);
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      bnd();
      guard++;
    end
    chk("tbl_drain", 32'(sb_q.size()), 32'd0);
    chk("tbl_busy_end",  32'(busy_o),       32'd0);
    chk("tbl_count_end", 32'(fifo_count_o), 32'd0);

    // ---- Reset in the middle of a long wait ----
    do_reset();
    push_cmd(5'd3, 8'h55, 16'd100);
    exp_write(5'd3, 8'h55);
    bnd();
    for (int i = 0; i < 10; i++) begin
      exp_idle();
      bnd();
    end
    chk("mid_busy", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    #2;
    chk("mid_rst_rw",    32'(audio_rw_no),  32'd1);
    chk("mid_rst_addr",  32'(audio_addr_o), 32'd0);
    chk("mid_rst_data",  32'(audio_data_o), 32'd0);
    chk("mid_rst_count", 32'(fifo_count_o), 32'd0);
    chk("mid_rst_busy",  32'(busy_o),       32'd0);
    reset_i = 1'b0;
    tick();

    // ---- CPU write wins over a ready FIFO head ----
    do_reset();
    cpu_sel_i   = 1'b1;
    cpu_rw_ni   = 1'b0;
    cpu_addr_i  = 5'd4;
    cpu_data_i  = 8'h11;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 5'd5;
    cmd_data_i  = 8'h9A;
    cmd_delay_i = 16'd0;
    exp_idle();
    bnd();
    chk("cpu_cnt0", 32'(fifo_count_o), 32'd1);
    exp_write(5'd4, 8'h11);
    bnd();
    chk("cpu_cnt1", 32'(fifo_count_o), 32'd1);
    exp_write(5'd5, 8'h9A);
    bnd();
    chk("cpu_cnt2", 32'(fifo_count_o), 32'd0);
    exp_idle();
    bnd();
    chk("cpu_busy", 32'(busy_o), 32'd0);

    // ---- Full FIFO, refused pushes, then flush during a wait ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("full_ready_pre", 32'(cmd_ready_o), 32'd1);
      push_cmd(5'(i), 8'(8'hC0 + i), 16'hFFFF);
    end
    chk("full_count", 32'(fifo_count_o), 32'd8);
    chk("full_ready", 32'(cmd_ready_o),  32'd0);
    push_cmd(5'd9, 8'hEE, 16'd0);
    chk("full_9th", 32'(fifo_count_o), 32'd8);
    // Push offered on the same boundary that pops the head: refused.
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 5'd10;
    cmd_data_i  = 8'hDD;
    cmd_delay_i = 16'd0;
    exp_write(5'd0, 8'hC0);
    bnd();
    chk("full_pop_count", 32'(fifo_count_o), 32'd7);
    chk("full_pop_ready", 32'(cmd_ready_o),  32'd1);
    exp_idle();
    bnd();
    chk("wait_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_count", 32'(fifo_count_o), 32'd0);
    chk("flush_busy",  32'(busy_o),       32'd0);
    push_cmd(5'd9, 8'h77, 16'd0);
    exp_write(5'd9, 8'h77);
    bnd();
    exp_idle();
    bnd();
    chk("flush_after_busy", 32'(busy_o), 32'd0);

`ifdef AUDIO_SEQ_LOOP_EN
    // ---- Loop replay ----
    do_reset();
    push_cmd(5'd0, 8'h01, 16'd1);
    push_cmd(5'd0, 8'h02, 16'd1);
    loop_i = 1'b1;
    #1;
    chk("loop_ready", 32'(cmd_ready_o), 32'd0);
    for (int r = 0; r < 2; r++) begin
      exp_write(5'd0, 8'h01);
      exp_idle();
      exp_write(5'd0, 8'h02);
      exp_idle();
    end
    for (int s = 0; s < 8; s++) begin
      bnd();
      chk("loop_count", 32'(fifo_count_o), 32'd2);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    loop_i  = 1'b0;
    chk("loop_flush", 32'(fifo_count_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
